fifo_rd_drain: RTL and testbench
================================

Name: fifo_rd_drain

Overview:
- Single-clock read-side consumer for the asynchronous FIFO. Sits in the rd_clk domain, on the FIFO's read port.
- Issues rd_enbl against empty, captures rd_data after the FIFO's read latency, and presents words on a valid/ready stream with a small elastic buffer.
- Also provides flush (drain and discard), a sticky underflow error and a transfer counter.

Parameters:
- DATA_W, 8, width of rd_data / out_data.
- BUF_DEPTH, 4, elastic buffer entries; power of two, at least 2.
- RD_LAT, 1, cycles from rd_enbl sampled high to rd_data valid; legal values 1..3.
- CNT_W, 16, width of xfer_cnt.

Ports:
- rd_clk  in  1  read-domain clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- rd_enbl  out  1  FIFO read request.
- rd_data  in  DATA_W  FIFO read data, valid RD_LAT cycles after an accepted rd_enbl.
- empty  in  1  FIFO empty.
- almost_empty  in  1  FIFO almost empty (status only, not gating).
- underflow  in  1  FIFO underflow pulse.
- out_valid  out  1  stream data valid.
- out_data  out  DATA_W  stream data.
- out_ready  in  1  downstream accept.
- flush  in  1  level request: drain FIFO and discard.
- flush_busy  out  1  high while in FLUSH.
- err_clr  in  1  clears err_underflow.
- err_underflow  out  1  sticky underflow error.
- xfer_cnt  out  CNT_W  words delivered on the stream, wraps.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Clock port is rd_clk, reset port is rstn.
- Reset values: rd_enbl=0, out_valid=0, out_data=0, flush_busy=0, err_underflow=0, xfer_cnt=0. In-flight pipeline and buffer pointers cleared.
- Reset mid-operation: in-flight reads are dropped and not recovered.
- Read issue, RUN state:
  - rd_enbl = !empty && (occupancy + inflight < BUF_DEPTH), where inflight is the number of issued reads not yet captured.
  - rd_enbl is registered, so empty is the value sampled on the previous edge.
  - rd_enbl is never asserted in a cycle where empty was sampled high.
- Read latency:
  - A RD_LAT-deep valid shift register tracks issued reads.
  - When its tail is set, rd_data is written into the buffer.
  - The credit rule guarantees the buffer never overflows.
- Stream side:
  - out_valid = occupancy != 0; out_data = head entry (registered).
  - A transfer occurs on out_valid && out_ready: pop, and xfer_cnt += 1, wrapping from 2^CNT_W-1 to 0.
  - Push and pop in the same cycle leave occupancy unchanged.
  - When the buffer is full, push only happens together with a pop.
  - While out_valid is high and out_ready is low, out_data is held stable.
- Throughput: with out_ready held high and the FIFO non-empty, one word per cycle after an initial fill latency of RD_LAT+1 cycles.
- State machine:
  - RUN to FLUSH: on flush=1.
  - In FLUSH:
    - rd_enbl continues whenever !empty.
    - Every captured word is discarded, not pushed.
    - Existing buffer contents are cleared on FLUSH entry.
    - out_valid=0 and flush_busy=1.
  - FLUSH to RUN: when flush=0, empty=1 and inflight=0 on the same edge.
  - flush deasserted while the FIFO is non-empty: stay in FLUSH until it drains.
  - xfer_cnt does not count discarded words.
- Errors:
  - err_underflow sets on any sampled underflow=1.
  - It is cleared only by err_clr=1 or reset. Set has priority over clear in the same cycle.
- Boundary cases:
  - empty rising while a read is in flight: the captured data is still pushed.
  - out_ready high with buffer empty: no effect.
  - Occupancy wraps via a pointer bit; full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}.

Decomposition:
- Package fifo_rd_pkg:
  - state enum rd_state_e {RUN, FLUSH}.
  - localparam default DATA_W.
  - function clog2-based pointer width.
- Sub-module fifo_rd_skid_buf: the BUF_DEPTH circular buffer with push/pop/occupancy/clear. The top level holds the FSM, credit logic, latency pipe, error flag and counter.

Test Plan:
- Reset: hold rstn=0 with empty=0 -> rd_enbl=0, out_valid=0, xfer_cnt=0. Release -> first rd_enbl on the 1st posedge after release.
- Streaming: FIFO preloaded with 0x01..0x10, out_ready=1, RD_LAT=1 -> out_data sequence 0x01..0x10 in order, one per cycle after a 2-cycle fill, xfer_cnt=16.
- Backpressure: out_ready=0 with 10 words available -> exactly BUF_DEPTH=4 reads issued, rd_enbl then 0, out_data=0x01 held. Set out_ready=1 -> remaining words arrive in order.
- Empty boundary: FIFO holds 1 word -> exactly one rd_enbl pulse, out_data=that word, no rd_enbl while empty=1.
- Flush: 3 words buffered plus 5 in FIFO, pulse flush for 1 cycle -> flush_busy=1, out_valid=0, 5 reads issued. Return to RUN once empty and inflight=0; xfer_cnt unchanged.
- Underflow: drive underflow=1 for one cycle -> err_underflow=1 and sticky. err_clr=1 -> 0. underflow and err_clr in the same cycle -> stays 1.

Source files
------------

// File: rtl/fifo_rd_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared types and helpers for the FIFO read-side drain logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

   // Top-level operating mode: normal streaming or drain-and-discard.
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } rd_state_e;

   localparam int DEF_DATA_W = 8;

   // Index width for a circular buffer of the given depth (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_drain_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_skid_buf
//  Description : Small circular elastic buffer with push/pop/clear and an
//                occupancy count. Pointers carry one extra wrap bit so that
//                full and empty are distinguishable.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BUF_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear,
   input  logic                          push,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head_data,
   output logic                          empty,
   output logic [ptr_w(BUF_DEPTH):0]     occupancy
);

   localparam int PW = ptr_w(BUF_DEPTH);

   logic [DATA_W-1:0] r_mem [BUF_DEPTH];
   logic [PW:0]       r_wr_ptr;
   logic [PW:0]       r_rd_ptr;
   logic              w_full;
   logic              w_do_push;
   logic              w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full    = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {PW{1'b0}}});
   assign w_do_pop  = pop && !empty;
   // A write into a full buffer is only legal when a slot frees on the same edge.
   assign w_do_push = push && (!w_full || w_do_pop);
   assign occupancy = r_wr_ptr - r_rd_ptr;
   assign head_data = r_mem[r_rd_ptr[PW-1:0]];

   // Pointer update; clear empties the buffer and overrides push/pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; zeroed at reset so the head word reads as zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push && !clear) begin
         r_mem[r_wr_ptr[PW-1:0]] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_drain
//  Description : Read-side consumer for the async FIFO. Issues credit-limited
//                reads, tracks read latency, buffers words and presents them
//                on a valid/ready stream. Supports flush, a sticky underflow
//                flag and a delivered-word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BUF_DEPTH = 4,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = 16
) (
   input  logic              rd_clk,
   input  logic              rstn,
   output logic              rd_enbl,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              empty,
   input  logic              almost_empty,
   input  logic              underflow,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic              flush_busy,
   input  logic              err_clr,
   output logic              err_underflow,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam int PW = ptr_w(BUF_DEPTH);
   // Wide enough for occupancy + pipe + outstanding request.
   localparam int CW = PW + 3;

   rd_state_e          r_state;
   logic [RD_LAT-1:0]  r_lat_pipe;
   logic               w_accept;
   logic               w_capture;
   logic               w_push;
   logic               w_pop;
   logic               w_clear;
   logic               w_buf_empty;
   logic [PW:0]        w_occ;
   logic [CW-1:0]      w_inflight;
   logic [CW-1:0]      w_credit_used;
   logic               unused_ok;

   assign unused_ok = &{1'b0, almost_empty};

   // The FIFO only honours a request when it is not empty on that edge.
   assign w_accept      = rd_enbl && !empty;
   assign w_capture     = r_lat_pipe[RD_LAT-1];
   assign w_push        = w_capture && (r_state == RUN);
   assign w_clear       = (r_state == RUN) && flush;
   assign out_valid     = (r_state == RUN) && !w_buf_empty;
   assign w_pop         = out_valid && out_ready;
   assign flush_busy    = (r_state == FLUSH);
   assign w_credit_used = CW'(w_occ) + w_inflight;

   // Outstanding reads: requests in the latency pipe plus the one on the wire.
   always_comb begin
      w_inflight = CW'(rd_enbl);
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + CW'(r_lat_pipe[i]);
      end
   end

   // Mode FSM and registered read request.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= RUN;
         rd_enbl <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (flush) begin
                  r_state <= FLUSH;
                  rd_enbl <= !empty;
               end else begin
                  rd_enbl <= !empty && (w_credit_used < CW'(BUF_DEPTH));
               end
            end
            FLUSH: begin
               rd_enbl <= !empty;
               if (!flush && empty && (w_inflight == '0)) r_state <= RUN;
            end
            default: begin
               r_state <= RUN;
               rd_enbl <= 1'b0;
            end
         endcase
      end
   end

   // Read-latency tracker: the tail marks the cycle rd_data is valid.
   generate
      if (RD_LAT == 1) begin : g_lat_one
         always_ff @(posedge rd_clk or negedge rstn) begin
            if (!rstn) r_lat_pipe <= '0;
            else       r_lat_pipe <= w_accept;
         end
      end else begin : g_lat_multi
         always_ff @(posedge rd_clk or negedge rstn) begin
            if (!rstn) r_lat_pipe <= '0;
            else       r_lat_pipe <= {r_lat_pipe[RD_LAT-2:0], w_accept};
         end
      end
   endgenerate

   // Sticky underflow flag; a new underflow wins over a clear.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn)          err_underflow <= 1'b0;
      else if (underflow) err_underflow <= 1'b1;
      else if (err_clr)   err_underflow <= 1'b0;
   end

   // Delivered-word counter, wraps naturally.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn)      xfer_cnt <= '0;
      else if (w_pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
   end

   fifo_rd_skid_buf #(
      .DATA_W    (DATA_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (rd_clk),
      .rstn      (rstn),
      .clear     (w_clear),
      .push      (w_push),
      .wr_data   (rd_data),
      .pop       (w_pop),
      .head_data (out_data),
      .empty     (w_buf_empty),
      .occupancy (w_occ)
   );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_drain
//  Description : Directed self-checking bench for fifo_rd_drain with a
//                behavioural one-cycle-latency FIFO read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;

   logic        rd_clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rd_enbl;
   logic [7:0]  rd_data = 8'h00;
   logic        empty = 1'b1;
   logic        almost_empty = 1'b0;
   logic        underflow = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        flush_busy;
   logic        err_clr = 1'b0;
   logic        err_underflow;
   logic [15:0] xfer_cnt;

   int tests = 0;
   int fails = 0;

   logic [7:0] fifo_q[$];
   int   rd_acc = 0;
   int   viol = 0;
   int   pulses = 0;
   logic prev_en = 1'b0;
   logic prev_empty = 1'b1;
   logic en_s, e_s;

   fifo_rd_drain #(
      .DATA_W    (8),
      .BUF_DEPTH (4),
      .RD_LAT    (1),
      .CNT_W     (16)
   ) dut (
      .rd_clk        (rd_clk),
      .rstn          (rstn),
      .rd_enbl       (rd_enbl),
      .rd_data       (rd_data),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .underflow     (underflow),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .flush         (flush),
      .flush_busy    (flush_busy),
      .err_clr       (err_clr),
      .err_underflow (err_underflow),
      .xfer_cnt      (xfer_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   // FIFO read port: a request is accepted when empty is low on the edge;
   // data appears shortly after that edge and stays until the next read.
   always @(posedge rd_clk) begin
      en_s = rd_enbl;
      e_s  = empty;
      if (en_s && prev_empty) viol++;
      if (en_s && !prev_en)   pulses++;
      prev_en    = en_s;
      prev_empty = e_s;
      if (en_s && !e_s) begin
         #1;
         rd_data = fifo_q.pop_front();
         rd_acc++;
         empty = (fifo_q.size() == 0);
      end
   end

   task automatic do_reset();
      rstn      = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      underflow = 1'b0;
      err_clr   = 1'b0;
      fifo_q.delete();
      empty     = 1'b1;
      repeat (2) @(negedge rd_clk);
      rstn = 1'b1;
      @(negedge rd_clk);
      rd_acc = 0;
      viol   = 0;
      pulses = 0;
   endtask

   task automatic test_reset();
      for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
      empty     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge rd_clk);
      tests++; if (rd_enbl !== 1'b0) begin fails++; $display("FAIL reset_rd_enbl: got %b, expected 0", rd_enbl); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
      tests++; if (xfer_cnt !== 16'd0) begin fails++; $display("FAIL reset_xfer_cnt: got %0d, expected 0", xfer_cnt); end
      tests++; if (flush_busy !== 1'b0 || err_underflow !== 1'b0) begin fails++; $display("FAIL reset_flags: got busy=%b err=%b, expected 0 0", flush_busy, err_underflow); end
      rstn = 1'b1;
      @(posedge rd_clk); #1;
      tests++; if (rd_enbl !== 1'b1) begin fails++; $display("FAIL reset_first_rd_enbl: got %b, expected 1", rd_enbl); end
   endtask

   task automatic test_streaming();
      logic [7:0] got[$];
      int first_c = -1;
      int last_c = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge rd_clk);
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (first_c < 0) first_c = c;
            last_c = c;
         end
      end
      tests++; if (got.size() != 16) begin fails++; $display("FAIL stream_count: got %0d, expected 16", got.size()); end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         tests++; if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL stream_data[%0d]: got %h, expected %h", i, got[i], 8'(i + 1)); end
      end
      tests++; if (first_c != 2) begin fails++; $display("FAIL stream_fill_latency: got %0d, expected 2", first_c); end
      tests++; if (last_c - first_c != 15) begin fails++; $display("FAIL stream_no_bubbles: got span %0d, expected 15", last_c - first_c); end
      tests++; if (xfer_cnt !== 16'd16) begin fails++; $display("FAIL stream_xfer_cnt: got %0d, expected 16", xfer_cnt); end
   endtask

   task automatic test_backpressure();
      logic [7:0] got[$];
      do_reset();
      for (int i = 1; i <= 10; i++) fifo_q.push_back(8'(i));
      empty = 1'b0;
      repeat (12) @(negedge rd_clk);
      tests++; if (rd_acc != 4) begin fails++; $display("FAIL bp_reads_issued: got %0d, expected 4", rd_acc); end
      tests++; if (rd_enbl !== 1'b0) begin fails++; $display("FAIL bp_rd_enbl_low: got %b, expected 0", rd_enbl); end
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin fails++; $display("FAIL bp_head: got valid=%b data=%h, expected 1 01", out_valid, out_data); end
      repeat (3) @(negedge rd_clk);
      tests++; if (out_data !== 8'h01) begin fails++; $display("FAIL bp_hold: got %h, expected 01", out_data); end
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid && out_ready) got.push_back(out_data);
         @(negedge rd_clk);
      end
      tests++; if (got.size() != 10) begin fails++; $display("FAIL bp_count: got %0d, expected 10", got.size()); end
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         tests++; if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL bp_data[%0d]: got %h, expected %h", i, got[i], 8'(i + 1)); end
      end
      tests++; if (xfer_cnt !== 16'd10) begin fails++; $display("FAIL bp_xfer_cnt: got %0d, expected 10", xfer_cnt); end
   endtask

   task automatic test_empty_boundary();
      logic [7:0] got[$];
      do_reset();
      out_ready = 1'b1;
      fifo_q.push_back(8'hA5);
      empty = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge rd_clk);
         if (out_valid && out_ready) got.push_back(out_data);
      end
      tests++; if (rd_acc != 1) begin fails++; $display("FAIL eb_reads: got %0d, expected 1", rd_acc); end
      tests++; if (pulses != 1) begin fails++; $display("FAIL eb_pulses: got %0d, expected 1", pulses); end
      tests++; if (viol != 0) begin fails++; $display("FAIL eb_rd_while_empty: got %0d, expected 0", viol); end
      tests++; if (got.size() != 1 || got[0] !== 8'hA5) begin fails++; $display("FAIL eb_data: got n=%0d first=%h, expected 1 a5", got.size(), (got.size() > 0) ? got[0] : 8'h00); end
      tests++; if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL eb_idle_ready: got cnt=%0d valid=%b, expected 1 0", xfer_cnt, out_valid); end
   endtask

   task automatic test_flush();
      logic [7:0] got[$];
      int waited = 0;
      do_reset();
      for (int i = 0; i < 4; i++) fifo_q.push_back(8'h11 + 8'(i));
      empty = 1'b0;
      repeat (10) @(negedge rd_clk);
      out_ready = 1'b1;
      @(negedge rd_clk);
      out_ready = 1'b0;
      tests++; if (xfer_cnt !== 16'd1 || out_data !== 8'h12) begin fails++; $display("FAIL fl_pre: got cnt=%0d data=%h, expected 1 12", xfer_cnt, out_data); end
      rd_acc = 0;
      for (int i = 0; i < 5; i++) fifo_q.push_back(8'h21 + 8'(i));
      empty = 1'b0;
      flush = 1'b1;
      @(negedge rd_clk);
      flush = 1'b0;
      tests++; if (flush_busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL fl_busy: got busy=%b valid=%b, expected 1 0", flush_busy, out_valid); end
      while (flush_busy === 1'b1 && waited < 30) begin
         @(negedge rd_clk);
         waited++;
      end
      tests++; if (flush_busy !== 1'b0) begin fails++; $display("FAIL fl_return_run: got busy=%b after %0d cycles, expected 0", flush_busy, waited); end
      tests++; if (rd_acc != 5) begin fails++; $display("FAIL fl_reads: got %0d, expected 5", rd_acc); end
      tests++; if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL fl_discard: got cnt=%0d valid=%b, expected 1 0", xfer_cnt, out_valid); end
      fifo_q.push_back(8'h77);
      empty = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge rd_clk);
         if (out_valid && out_ready) got.push_back(out_data);
      end
      tests++; if (got.size() != 1 || got[0] !== 8'h77 || xfer_cnt !== 16'd2) begin fails++; $display("FAIL fl_after: got n=%0d cnt=%0d, expected 1 word 77 cnt 2", got.size(), xfer_cnt); end
   endtask

   task automatic test_underflow();
      do_reset();
      underflow = 1'b1;
      @(negedge rd_clk);
      underflow = 1'b0;
      tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set: got %b, expected 1", err_underflow); end
      repeat (3) @(negedge rd_clk);
      tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b, expected 1", err_underflow); end
      err_clr = 1'b1;
      @(negedge rd_clk);
      err_clr = 1'b0;
      tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b, expected 0", err_underflow); end
      underflow = 1'b1;
      err_clr   = 1'b1;
      @(negedge rd_clk);
      underflow = 1'b0;
      err_clr   = 1'b0;
      tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set_priority: got %b, expected 1", err_underflow); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_boundary();
      test_flush();
      test_underflow();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
